// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - RS entry allocation, wake-up tracking and oldest-ready issue select
// Three alloc slots and three issue ports over BUF_COUNT entries ordered by an age matrix.
module rs_issue_sched #(
  parameter int BUF_COUNT = 32,
  parameter int BANK_SIZE = BUF_COUNT / 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic [2:0]                    newEn_i,
  input  logic [1:0]                    newPort0_i,
  input  logic [1:0]                    newPort1_i,
  input  logic [1:0]                    newPort2_i,
  input  logic [2:0]                    newRdy0_i,
  input  logic [2:0]                    newRdy1_i,
  input  logic [2:0]                    newRdy2_i,
  input  logic [BUF_COUNT-1:0]          wakeA_i,
  input  logic [BUF_COUNT-1:0]          wakeB_i,
  input  logic [BUF_COUNT-1:0]          wakeS_i,
  output logic [BUF_COUNT-1:0]          newRsSelect0_o,
  output logic [BUF_COUNT-1:0]          newRsSelect1_o,
  output logic [BUF_COUNT-1:0]          newRsSelect2_o,
  output logic                          doStall_o,
  output logic [2:0][BUF_COUNT-1:0]     outRsSelect_o,
  output logic [2:0][3:0]               outBank_o,
  output logic [2:0]                    rsFound_o,
  output logic [2:0]                    rsFoundNZ_o,
  output logic [$clog2(BUF_COUNT):0]    freeCnt_o
);
  localparam int CW = $clog2(BUF_COUNT) + 1;
  localparam logic [BUF_COUNT-1:0] ONE = BUF_COUNT'(1);
  localparam logic [CW-1:0] FULL = CW'(BUF_COUNT);

  logic [BUF_COUNT-1:0]                valid_q, valid_d, rdya_q, rdya_d, rdyb_q, rdyb_d, rdys_q, rdys_d;
  logic [BUF_COUNT-1:0][1:0]           port_q, port_d;
  logic [BUF_COUNT-1:0][BUF_COUNT-1:0] age_q, age_d;
  logic [2:0][BUF_COUNT-1:0]           sel_q;
  logic [2:0][3:0]                     bank_q;
  logic [2:0]                          found_q, found_nz_q;
  logic [CW-1:0]                       free_q, free_d;

  logic [2:0][1:0]                     new_port;
  logic [2:0][2:0]                     new_rdy;
  logic [2:0][BUF_COUNT-1:0]           slot_sel, elig_p, pick;
  logic [2:0][3:0]                     pick_bank;
  logic [2:0]                          pick_found;
  logic [BUF_COUNT-1:0]                taken, avail, eligible, issued;
  logic [CW-1:0]                       req_cnt, iss_cnt;
  logic                                alloc_ok, do_alloc;

  // Slots take the lowest free entry not already claimed by a lower slot.
  always_comb begin
    new_port = {newPort2_i, newPort1_i, newPort0_i};
    new_rdy  = {newRdy2_i, newRdy1_i, newRdy0_i};
    taken    = '0;
    avail    = '0;
    slot_sel = '0;
    req_cnt  = '0;
    for (int k = 0; k < 3; k++) begin
      avail = ~valid_q & ~taken;
      if (newEn_i[k]) begin
        slot_sel[k] = avail & (~avail + ONE);
        req_cnt     = req_cnt + CW'(1);
      end
      taken = taken | slot_sel[k];
    end
    alloc_ok = (req_cnt <= free_q);
    do_alloc = alloc_ok & ~stall_i & ~flush_i;
  end

  assign doStall_o      = ~alloc_ok;
  assign newRsSelect0_o = do_alloc ? slot_sel[0] : '0;
  assign newRsSelect1_o = do_alloc ? slot_sel[1] : '0;
  assign newRsSelect2_o = do_alloc ? slot_sel[2] : '0;

  // An entry wins its port when no other eligible entry of that port is older.
  always_comb begin
    eligible   = valid_q & rdya_q & rdyb_q & rdys_q;
    elig_p     = '0;
    pick       = '0;
    pick_bank  = '0;
    pick_found = '0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < BUF_COUNT; i++)
        elig_p[p][i] = eligible[i] & (port_q[i] == 2'(p));
      for (int i = 0; i < BUF_COUNT; i++)
        pick[p][i] = elig_p[p][i] & ~|(age_q[i] & elig_p[p]);
      for (int b = 0; b < 4; b++)
        pick_bank[p][b] = |pick[p][b*BANK_SIZE +: BANK_SIZE];
      pick_found[p] = |pick[p];
    end
    issued = pick[0] | pick[1] | pick[2];
  end

  always_comb begin
    valid_d = valid_q;
    rdya_d  = rdya_q | (wakeA_i & valid_q);
    rdyb_d  = rdyb_q | (wakeB_i & valid_q);
    rdys_d  = rdys_q | (wakeS_i & valid_q);
    port_d  = port_q;
    age_d   = age_q;
    iss_cnt = '0;
    if (!stall_i) begin
      valid_d = valid_d & ~issued;
      for (int p = 0; p < 3; p++)
        iss_cnt = iss_cnt + CW'(pick_found[p]);
    end
    if (do_alloc) begin
      // Nobody is younger than a fresh entry; clear its column before writing rows.
      for (int r = 0; r < BUF_COUNT; r++)
        age_d[r] = age_d[r] & ~taken;
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < BUF_COUNT; i++) begin
          if (slot_sel[k][i]) begin
            valid_d[i] = 1'b1;
            port_d[i]  = (new_port[k] == 2'd3) ? 2'd0 : new_port[k];
            rdya_d[i]  = new_rdy[k][0];
            rdyb_d[i]  = new_rdy[k][1];
            rdys_d[i]  = new_rdy[k][2];
            age_d[i]   = valid_q | ((k > 0) ? slot_sel[0] : '0) | ((k > 1) ? slot_sel[1] : '0);
          end
        end
      end
    end
    free_d = free_q + iss_cnt - (do_alloc ? req_cnt : '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      rdya_q     <= '0;
      rdyb_q     <= '0;
      rdys_q     <= '0;
      port_q     <= '0;
      age_q      <= '0;
      sel_q      <= '0;
      bank_q     <= '0;
      found_q    <= '0;
      found_nz_q <= '0;
      free_q     <= FULL;
    end else if (flush_i) begin
      valid_q    <= '0;
      rdya_q     <= '0;
      rdyb_q     <= '0;
      rdys_q     <= '0;
      age_q      <= '0;
      sel_q      <= '0;
      bank_q     <= '0;
      found_q    <= '0;
      found_nz_q <= '0;
      free_q     <= FULL;
    end else begin
      valid_q    <= valid_d;
      rdya_q     <= rdya_d;
      rdyb_q     <= rdyb_d;
      rdys_q     <= rdys_d;
      port_q     <= port_d;
      age_q      <= age_d;
      free_q     <= free_d;
      found_q    <= pick_found & {3{~stall_i}};
      found_nz_q <= pick_found & {3{~stall_i}};
      if (!stall_i) begin
        sel_q  <= pick;
        bank_q <= pick_bank;
      end
    end
  end

  assign outRsSelect_o = sel_q;
  assign outBank_o     = bank_q;
  assign rsFound_o     = found_q;
  assign rsFoundNZ_o   = found_nz_q;
  assign freeCnt_o     = free_q;

endmodule
